// File: rtl/bus_slave_regfile_pkg.sv
// bus_slave_regfile_pkg: shared bus constants and the slave FSM state encoding.
package bus_slave_regfile_pkg;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;
    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;
    localparam int BUS_SLV_STATE_W = 2;
    typedef enum logic [BUS_SLV_STATE_W-1:0] {
        BUS_SLV_IDLE = 2'd0,
        BUS_SLV_WAIT = 2'd1,
        BUS_SLV_ACK  = 2'd2
    } bus_slv_state_e;
endpackage

// File: rtl/bus_slave_regfile_if.sv
// bus_slave_regfile_if: shared-bus request/response signals seen by one slave.
interface bus_slave_regfile_if;
    import bus_slave_regfile_pkg::*;
    logic                   cs_;
    logic                   as_;
    logic                   rw;
    logic [WORD_ADDR_W-1:0] addr;
    logic [WORD_DATA_W-1:0] wr_data;
    logic [WORD_DATA_W-1:0] rd_data;
    logic                   rdy_;
    modport master (output cs_, as_, rw, addr, wr_data, input rd_data, rdy_);
    modport slave  (input cs_, as_, rw, addr, wr_data, output rd_data, rdy_);
endinterface

// File: rtl/bus_slave_ctrl.sv
// bus_slave_ctrl: slave handshake FSM with wait-state counter, registered rdy_
// and write/read strobes that fire on the edge entering ACK.
module bus_slave_ctrl
    import bus_slave_regfile_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic reset_,
    input  logic cs_,
    input  logic as_,
    input  logic rw,
    output logic accept,
    output logic wr_en,
    output logic rd_en,
    output logic rdy_
);
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);
    bus_slv_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic rw_q, rw_d, rdy_q, rdy_d, req, go_ack;
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= BUS_SLV_IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            rdy_q   <= DISABLE_;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            rdy_q   <= rdy_d;
        end
    end
    always_comb begin
        req     = cs_ == ENABLE_ && as_ == ENABLE_;
        accept  = state_q == BUS_SLV_IDLE && req;
        // Dropping the request while waiting aborts back to IDLE; ACK always returns to IDLE.
        state_d = accept ? (WAIT_CYCLES == 0 ? BUS_SLV_ACK : BUS_SLV_WAIT)
                : state_q == BUS_SLV_WAIT && req ? (cnt_q == '0 ? BUS_SLV_ACK : BUS_SLV_WAIT)
                : BUS_SLV_IDLE;
        cnt_d   = accept ? CNT_INIT
                : state_q == BUS_SLV_WAIT && cnt_q != '0 ? cnt_q - 4'd1 : cnt_q;
        rw_d    = accept ? rw : rw_q;
        go_ack  = state_d == BUS_SLV_ACK;
        wr_en   = go_ack && rw_d == WRITE;
        rd_en   = go_ack && rw_d == READ;
        rdy_d   = go_ack ? ENABLE_ : DISABLE_;
    end
    assign rdy_ = rdy_q;
endmodule

// File: rtl/bus_slave_regfile.sv
// bus_slave_regfile: wait-stated bus slave backed by a 32-bit register file.
// Define BUS_SLAVE_IRQ_EN to add the irq output (top reg = status, next = mask).
module bus_slave_regfile
    import bus_slave_regfile_pkg::*;
#(
    parameter int DEPTH_LOG2  = 3,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset_,
    bus_slave_regfile_if.slave  bus
`ifdef BUS_SLAVE_IRQ_EN
    ,
    output logic                irq
`endif
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    logic [WORD_DATA_W-1:0] regs_q [DEPTH];
    logic [WORD_DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH_LOG2-1:0]  idx_q, idx_d;
    logic [WORD_DATA_W-1:0] wdata_q, wdata_d, rd_data_q, rd_data_d;
    logic accept, wr_en, rd_en, unused_addr;
`ifdef BUS_SLAVE_IRQ_EN
    logic irq_q, irq_d;
    assign irq = irq_q;
`endif
    assign unused_addr = ^bus.addr[WORD_ADDR_W-1:DEPTH_LOG2];
    assign bus.rd_data = rd_data_q;
    bus_slave_ctrl #(.WAIT_CYCLES(WAIT_CYCLES)) u_ctrl (
        .clk    (clk),
        .reset_ (reset_),
        .cs_    (bus.cs_),
        .as_    (bus.as_),
        .rw     (bus.rw),
        .accept (accept),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .rdy_   (bus.rdy_)
    );
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            idx_q     <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
`ifdef BUS_SLAVE_IRQ_EN
            irq_q     <= 1'b0;
`endif
        end else begin
            regs_q    <= regs_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            rd_data_q <= rd_data_d;
`ifdef BUS_SLAVE_IRQ_EN
            irq_q     <= irq_d;
`endif
        end
    end
    // With zero wait states the strobes fire on the accept edge, so use the live request.
    always_comb begin
        idx_d   = accept ? bus.addr[DEPTH_LOG2-1:0] : idx_q;
        wdata_d = accept ? bus.wr_data : wdata_q;
        regs_d  = regs_q;
        if (wr_en) regs_d[idx_d] = wdata_d;
`ifdef BUS_SLAVE_IRQ_EN
        // Status bits toggle on write: a 1 clears a pending bit, or raises a clear one.
        if (wr_en && &idx_d) regs_d[DEPTH-1] = regs_q[DEPTH-1] ^ wdata_d;
        irq_d = |(regs_q[DEPTH-1] & regs_q[DEPTH-2]);
`endif
        rd_data_d = rd_en ? regs_q[idx_d] : '0;
    end
endmodule

// File: tb/tb_bus_slave_regfile.sv
// tb_bus_slave_regfile: directed bench over four slaves with WAIT_CYCLES 1, 0, 15, 4
// sharing one bus; each slave is selected by its own chip select.
module tb_bus_slave_regfile;
    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic [3:0]  cs_n = 4'hF;
    logic        as_ = 1'b1;
    logic        rw = 1'b1;
    logic [29:0] addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  rdy_v;
    logic [31:0] rd_v [4];
`ifdef BUS_SLAVE_IRQ_EN
    logic [3:0]  irq_v;
`endif
    int cyc = 0;
    int pass_cnt = 0;
    int total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        bus_slave_regfile_if bus ();
        assign bus.cs_     = cs_n[g];
        assign bus.as_     = as_;
        assign bus.rw      = rw;
        assign bus.addr    = addr;
        assign bus.wr_data = wr_data;
        assign rdy_v[g]    = bus.rdy_;
        assign rd_v[g]     = bus.rd_data;
        bus_slave_regfile #(
            .DEPTH_LOG2  (3),
            .WAIT_CYCLES (g == 0 ? 1 : g == 1 ? 0 : g == 2 ? 15 : 4)
        ) u_dut (
            .clk    (clk),
            .reset_ (reset_),
            .bus    (bus)
`ifdef BUS_SLAVE_IRQ_EN
            ,
            .irq    (irq_v[g])
`endif
        );
    end

    // One transfer on slave s; lat counts cycles after the accept edge (1 = the next cycle).
    task automatic xfer(input int s, input logic r, input logic [29:0] a, input logic [31:0] d,
                        output logic [31:0] got, output int lat, output int at, output int bad);
        got = '0; lat = -1; at = -1; bad = 0;
        @(negedge clk);
        cs_n = 4'hF; cs_n[s] = 1'b0; as_ = 1'b0; rw = r; addr = a; wr_data = d;
        @(posedge clk);
        #1 rw = ~r; wr_data = ~d;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            if (n > 1) begin @(posedge clk); #1; end
            if (rdy_v[s] === 1'b0) begin lat = n; at = cyc; got = rd_v[s]; end
            else if (rd_v[s] !== '0) bad++;
        end
        @(negedge clk);
        as_ = 1'b1; cs_n = 4'hF;
        @(posedge clk); #1;
        if (rdy_v[s] !== 1'b1 || rd_v[s] !== '0) bad++;
    endtask

    task automatic test_reset;
        logic [31:0] got; int lat, at, bad;
        reset_ = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset_ = 1'b1; #1;
        total++; if (rdy_v !== 4'hF) $display("FAIL reset_rdy: got %b want 1111", rdy_v); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total++; if (rd_v[i] !== '0) $display("FAIL reset_rd%0d: got %h want 0", i, rd_v[i]); else pass_cnt++;
        end
        for (int i = 0; i < 8; i++) begin
            xfer(1, 1'b1, 30'(i), '0, got, lat, at, bad);
            total++;
            if (got !== '0 || lat !== 1 || bad !== 0)
                $display("FAIL reset_read%0d: got %h lat %0d bad %0d want 0 lat 1 bad 0", i, got, lat, bad);
            else pass_cnt++;
        end
    endtask

    task automatic test_write_read;
        logic [31:0] got; int lat, at, bad;
        xfer(0, 1'b0, 30'h3, 32'hDEADBEEF, got, lat, at, bad);
        total++; if (lat !== 2 || got !== '0) $display("FAIL w1_write: lat %0d rd %h want lat 2 rd 0", lat, got); else pass_cnt++;
        xfer(0, 1'b1, 30'h3, '0, got, lat, at, bad);
        total++; if (got !== 32'hDEADBEEF) $display("FAIL w1_read: got %h want deadbeef", got); else pass_cnt++;
        total++; if (lat !== 2 || bad !== 0) $display("FAIL w1_read_timing: lat %0d bad %0d want 2 0", lat, bad); else pass_cnt++;
    endtask

    task automatic test_latency;
        logic [31:0] got; int lat, at, bad;
        xfer(1, 1'b0, 30'h5, 32'hCAFE0001, got, lat, at, bad);
        total++; if (lat !== 1) $display("FAIL w0_write_lat: got %0d want 1", lat); else pass_cnt++;
        xfer(1, 1'b1, 30'h5, '0, got, lat, at, bad);
        total++; if (lat !== 1 || got !== 32'hCAFE0001) $display("FAIL w0_read: lat %0d got %h want 1 cafe0001", lat, got); else pass_cnt++;
        xfer(2, 1'b0, 30'h2, 32'h0F0F0F0F, got, lat, at, bad);
        total++; if (lat !== 16) $display("FAIL w15_write_lat: got %0d want 16", lat); else pass_cnt++;
        xfer(2, 1'b1, 30'h2, '0, got, lat, at, bad);
        total++; if (lat !== 16 || got !== 32'h0F0F0F0F || bad !== 0)
            $display("FAIL w15_read: lat %0d got %h bad %0d want 16 0f0f0f0f 0", lat, got, bad);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] got; int lat, at0, at1, at2, bad;
        xfer(1, 1'b0, 30'h2, 32'h11111111, got, lat, at0, bad);
        xfer(1, 1'b0, 30'h4, 32'h22222222, got, lat, at1, bad);
        xfer(1, 1'b0, 30'h6, 32'h33333333, got, lat, at2, bad);
        total++; if (at1 - at0 !== 2 || at2 - at1 !== 2)
            $display("FAIL b2b_w0_period: got %0d %0d want 2 2", at1 - at0, at2 - at1);
        else pass_cnt++;
        xfer(1, 1'b1, 30'h4, '0, got, lat, at0, bad);
        total++; if (got !== 32'h22222222) $display("FAIL b2b_w0_read: got %h want 22222222", got); else pass_cnt++;
        xfer(2, 1'b0, 30'h6, 32'h44444444, got, lat, at0, bad);
        xfer(2, 1'b1, 30'h6, '0, got, lat, at1, bad);
        total++; if (at1 - at0 !== 17 || got !== 32'h44444444)
            $display("FAIL b2b_w15: period %0d got %h want 17 44444444", at1 - at0, got);
        else pass_cnt++;
    endtask

    task automatic test_abort;
        logic [31:0] got; int lat, at, bad, lows;
        xfer(3, 1'b0, 30'h1, 32'h0BADF00D, got, lat, at, bad);
        total++; if (lat !== 5) $display("FAIL w4_write_lat: got %0d want 5", lat); else pass_cnt++;
        lows = 0;
        @(negedge clk);
        cs_n = 4'b0111; as_ = 1'b0; rw = 1'b0; addr = 30'h1; wr_data = 32'h12345678;
        repeat (3) begin @(posedge clk); #1; if (rdy_v[3] !== 1'b1) lows++; end
        @(negedge clk); as_ = 1'b1;
        repeat (10) begin @(posedge clk); #1; if (rdy_v[3] !== 1'b1) lows++; end
        cs_n = 4'hF;
        total++; if (lows !== 0) $display("FAIL abort_rdy: got %0d rdy cycles want 0", lows); else pass_cnt++;
        xfer(3, 1'b1, 30'h1, '0, got, lat, at, bad);
        total++; if (got !== 32'h0BADF00D || lat !== 5) $display("FAIL abort_read: got %h lat %0d want 0badf00d 5", got, lat); else pass_cnt++;
    endtask

    task automatic test_addr_wrap;
        logic [31:0] got; int lat, at, bad;
        xfer(0, 1'b0, 30'h3FFFFFF9, 32'hA5A5A5A5, got, lat, at, bad);
        xfer(0, 1'b1, 30'h1, '0, got, lat, at, bad);
        total++; if (got !== 32'hA5A5A5A5) $display("FAIL wrap_read: got %h want a5a5a5a5", got); else pass_cnt++;
        xfer(0, 1'b1, 30'h3, '0, got, lat, at, bad);
        total++; if (got !== 32'hDEADBEEF) $display("FAIL wrap_neighbour: got %h want deadbeef", got); else pass_cnt++;
    endtask

    task automatic test_cs;
        int lows = 0;
        @(negedge clk);
        cs_n = 4'hF; as_ = 1'b0; rw = 1'b0; addr = 30'h3; wr_data = 32'h99999999;
        repeat (20) begin @(posedge clk); #1; if (rdy_v !== 4'hF) lows++; end
        @(negedge clk); as_ = 1'b1;
        total++; if (lows !== 0) $display("FAIL cs_gate: got %0d rdy cycles want 0", lows); else pass_cnt++;
    endtask

`ifdef BUS_SLAVE_IRQ_EN
    task automatic test_irq;
        logic [31:0] got; int lat, at, bad;
        xfer(1, 1'b0, 30'h6, 32'h1, got, lat, at, bad);
        total++; if (irq_v[1] !== 1'b0) $display("FAIL irq_mask_only: got %b want 0", irq_v[1]); else pass_cnt++;
        xfer(1, 1'b0, 30'h7, 32'h1, got, lat, at, bad);
        total++; if (irq_v[1] !== 1'b1) $display("FAIL irq_set: got %b want 1", irq_v[1]); else pass_cnt++;
        xfer(1, 1'b0, 30'h7, 32'h1, got, lat, at, bad);
        total++; if (irq_v[1] !== 1'b0) $display("FAIL irq_clear: got %b want 0", irq_v[1]); else pass_cnt++;
        xfer(1, 1'b1, 30'h7, '0, got, lat, at, bad);
        total++; if (got !== '0) $display("FAIL irq_status_read: got %h want 0", got); else pass_cnt++;
        xfer(1, 1'b0, 30'h7, 32'h1, got, lat, at, bad);
    endtask
`endif

    task automatic test_reset_mid;
        logic [31:0] got; int lat, at, bad, lows;
        @(negedge clk);
        cs_n = 4'b1011; as_ = 1'b0; rw = 1'b0; addr = 30'h5; wr_data = 32'h00000077;
        repeat (5) @(posedge clk);
        @(negedge clk); reset_ = 1'b0; #1;
        as_ = 1'b1; cs_n = 4'hF;
        total++; if (rdy_v !== 4'hF) $display("FAIL midreset_rdy: got %b want 1111", rdy_v); else pass_cnt++;
`ifdef BUS_SLAVE_IRQ_EN
        total++; if (irq_v !== 4'h0) $display("FAIL midreset_irq: got %b want 0000", irq_v); else pass_cnt++;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk); reset_ = 1'b1;
        lows = 0;
        repeat (20) begin @(posedge clk); #1; if (rdy_v !== 4'hF) lows++; end
        total++; if (lows !== 0) $display("FAIL midreset_no_rdy: got %0d want 0", lows); else pass_cnt++;
        xfer(2, 1'b1, 30'h5, '0, got, lat, at, bad);
        total++; if (got !== '0 || lat !== 16) $display("FAIL midreset_dropped: got %h lat %0d want 0 16", got, lat); else pass_cnt++;
        xfer(0, 1'b1, 30'h3, '0, got, lat, at, bad);
        total++; if (got !== '0) $display("FAIL midreset_cleared: got %h want 0", got); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_latency();
        test_back_to_back();
        test_abort();
        test_addr_wrap();
        test_cs();
`ifdef BUS_SLAVE_IRQ_EN
        test_irq();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
